mips_fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It holds the program counter, selects the next PC from sequential or decode-stage redirect sources, reads the instruction memory, and presents the instruction, PC+4 and PC+8 to the IF/ID pipeline register. Decode resolves branches, jumps and jr, and the instruction already in fetch is the delay slot. A synchronous load port writes program words into the instruction memory.

---
 rtl/mips_fetch_stage.sv | 94 +++++++++
 tb/tb_mips_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// ============================================================================
// mips_fetch_stage : MIPS IF stage - PC register, next-PC mux, instr memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  npc_sel,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   input  logic [31:0] pc4_d,
   input  logic        im_we,
   input  logic [31:0] im_waddr,
   input  logic [31:0] im_wdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_f,
   output logic [31:0] pc4_f,
   output logic [31:0] pc8_f,
   output logic        addr_err
);

   localparam int AW = $clog2(IM_WORDS);

   localparam logic [1:0] SEL_SEQ    = 2'd0;
   localparam logic [1:0] SEL_BRANCH = 2'd1;
   localparam logic [1:0] SEL_JUMP   = 2'd2;
   localparam logic [1:0] SEL_REG    = 2'd3;

   logic [31:0] mem [IM_WORDS];

   logic [31:0] pc;
   logic [31:0] npc;
   logic [31:0] branch_off;
   logic [31:0] rd_off;
   logic [31:0] wr_off;
   logic        rd_in_range;
   logic        wr_ok;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;

   assign pc4_f = pc + 32'd4;
   assign pc8_f = pc + 32'd8;
   assign pc_f  = pc;

   assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      npc = pc4_f;
      case (npc_sel)
         SEL_SEQ:    npc = pc4_f;
         SEL_BRANCH: npc = branch_taken ? (pc4_d + branch_off) : pc4_f;
         SEL_JUMP:   npc = {pc4_d[31:28], instr_index, 2'b00};
         SEL_REG:    npc = jr_target;
         default:    npc = pc4_f;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (en) begin
         pc <= npc;
      end
   end

   // Offset from the memory base; anything above the word-index field is out of range.
   assign rd_off      = pc - RESET_PC;
   assign rd_in_range = (pc >= RESET_PC) && ((rd_off >> (AW + 2)) == 32'd0);
   assign rd_idx      = rd_off[AW+1:2];
   assign addr_err    = (pc[1:0] != 2'b00) || !rd_in_range;
   assign instr_f     = addr_err ? 32'h0 : mem[rd_idx];

   assign wr_off = im_waddr - RESET_PC;
   assign wr_ok  = im_we && (im_waddr[1:0] == 2'b00) && (im_waddr >= RESET_PC)
                   && ((wr_off >> (AW + 2)) == 32'd0);
   assign wr_idx = wr_off[AW+1:2];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_idx] <= im_wdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
// Testbench for mips_fetch_stage: directed steps plus randomized traffic checked
// against an address-level reference model.
`default_nettype none

module tb_mips_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          IM_WORDS = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  npc_sel = 2'd0;
   logic        branch_taken = 1'b0;
   logic [15:0] imm16 = '0;
   logic [25:0] instr_index = '0;
   logic [31:0] jr_target = '0;
   logic [31:0] pc4_d = '0;
   logic        im_we = 1'b0;
   logic [31:0] im_waddr = '0;
   logic [31:0] im_wdata = '0;
   logic [31:0] pc_f, instr_f, pc4_f, pc8_f;
   logic        addr_err;

   mips_fetch_stage #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
      .clk(clk), .rst(rst), .en(en), .npc_sel(npc_sel),
      .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
      .jr_target(jr_target), .pc4_d(pc4_d), .im_we(im_we),
      .im_waddr(im_waddr), .im_wdata(im_wdata), .pc_f(pc_f),
      .instr_f(instr_f), .pc4_f(pc4_f), .pc8_f(pc8_f), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] pc_m;
   logic [31:0] mm [bit [31:0]];

   function automatic bit in_mem(input logic [31:0] a);
      return (a >= RESET_PC) && (((a - RESET_PC) / 4) < 32'(IM_WORDS));
   endfunction

   function automatic bit err_m(input logic [31:0] a);
      return ((a % 4) != 0) || !in_mem(a);
   endfunction

   function automatic logic [31:0] instr_m(input logic [31:0] a);
      if (err_m(a)) return 32'h0;
      if (mm.exists(a)) return mm[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] next_pc_m();
      int off;
      case (npc_sel)
         2'd1: begin
            if (!branch_taken) return pc_m + 4;
            off = int'($signed(imm16));
            return pc4_d + 32'(off * 4);
         end
         2'd2: return (pc4_d & 32'hF000_0000) + 32'(instr_index) * 4;
         2'd3: return jr_target;
         default: return pc_m + 4;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc_f", pc_f, pc_m);
      chk("pc4_f", pc4_f, pc_m + 4);
      chk("pc8_f", pc8_f, pc_m + 8);
      chk("addr_err", {31'b0, addr_err}, {31'b0, err_m(pc_m)});
      chk("instr_f", instr_f, instr_m(pc_m));
   endtask

   // One clock edge: model computes from pre-edge inputs, then compares after the edge.
   task automatic tick();
      logic [31:0] nxt;
      bit          do_w;
      nxt  = next_pc_m();
      do_w = im_we && (im_waddr[1:0] == 2'b00) && in_mem(im_waddr);
      @(posedge clk);
      if (do_w) mm[im_waddr] = im_wdata;
      if (en && !rst) pc_m = nxt;
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] old_word;

      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      pc_m = RESET_PC;
      #1;
      chk("reset_pc", pc_f, 32'h0000_3000);
      chk("reset_pc4", pc4_f, 32'h0000_3004);
      chk("reset_pc8", pc8_f, 32'h0000_3008);

      // preload every word while in reset
      @(posedge clk); #1;
      im_we = 1'b1;
      for (int i = 0; i < IM_WORDS; i++) begin
         im_waddr = RESET_PC + 32'(4 * i);
         im_wdata = (i == 1) ? 32'h2408_0005 : $urandom;
         tick();
      end
      // dropped writes: past the end, below the base, misaligned
      im_wdata = 32'hDEAD_BEEF;
      im_waddr = RESET_PC + 32'(4 * IM_WORDS); tick();
      im_waddr = RESET_PC - 4;                 tick();
      im_waddr = RESET_PC + 9;                 tick();
      im_we = 1'b0;
      chk("word0_after_drops", instr_f, mm[RESET_PC]);

      // sequential run
      rst = 1'b0;
      en = 1'b1;
      npc_sel = 2'd0;
      tick();
      chk("load_fetch", instr_f, 32'h2408_0005);
      tick();
      chk("word2_after_misaligned_drop", instr_f, mm[RESET_PC + 8]);
      tick();
      chk("seq_3cycles", pc_f, 32'h0000_300C);

      // branch taken / not taken
      npc_sel = 2'd1; pc4_d = 32'h3010; imm16 = 16'hFFFC; branch_taken = 1'b1;
      tick();
      chk("branch_taken", pc_f, 32'h0000_3000);
      branch_taken = 1'b0;
      tick();
      chk("branch_not_taken", pc_f, 32'h0000_3004);

      // jump and jr
      npc_sel = 2'd2; pc4_d = 32'h3008; instr_index = 26'h0000C10;
      tick();
      chk("jump", pc_f, 32'h0000_3040);
      npc_sel = 2'd3; jr_target = 32'h3002;
      tick();
      chk("jr_misaligned_pc", pc_f, 32'h0000_3002);
      chk("jr_misaligned_err", {31'b0, addr_err}, 32'd1);
      chk("jr_misaligned_instr", instr_f, 32'h0);

      // stall with a jump pending
      jr_target = 32'h3020; tick();
      held = pc_f;
      en = 1'b0; npc_sel = 2'd2; pc4_d = 32'h3008; instr_index = 26'h0000C10;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall_pc", pc_f, held);
      end
      en = 1'b1;
      tick();
      chk("stall_release_jump", pc_f, 32'h0000_3040);

      // range boundaries
      npc_sel = 2'd3; jr_target = RESET_PC + 32'(4 * IM_WORDS);
      tick();
      chk("end_err", {31'b0, addr_err}, 32'd1);
      chk("end_instr", instr_f, 32'h0);
      jr_target = RESET_PC - 4;
      tick();
      chk("below_err", {31'b0, addr_err}, 32'd1);
      jr_target = RESET_PC + 32'(4 * (IM_WORDS - 1));
      tick();
      chk("last_word_ok", {31'b0, addr_err}, 32'd0);

      // write and read of the same word in one cycle
      jr_target = 32'h3010; tick();
      en = 1'b0;
      old_word = mm[32'h3010];
      im_we = 1'b1; im_waddr = 32'h3010; im_wdata = 32'hA5A5_5A5A;
      #1;
      chk("rw_old_before_edge", instr_f, old_word);
      tick();
      chk("rw_new_after_edge", instr_f, 32'hA5A5_5A5A);
      im_we = 1'b0;

      // asynchronous reset in the middle of a redirect
      en = 1'b1; npc_sel = 2'd2;
      #2 rst = 1'b1;
      pc_m = RESET_PC;
      #1;
      chk("async_reset_mid_redirect", pc_f, 32'h0000_3000);
      check_all();
      rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         en           = ($urandom_range(0, 3) != 0);
         npc_sel      = 2'($urandom_range(0, 3));
         branch_taken = 1'($urandom_range(0, 1));
         imm16        = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 31) - 16);
         pc4_d        = ($urandom_range(0, 7) != 0) ? pc_m + 4 : $urandom;
         instr_index  = ($urandom_range(0, 3) != 0)
                        ? 26'((RESET_PC >> 2) + 32'($urandom_range(0, IM_WORDS - 1)))
                        : 26'($urandom);
         jr_target    = ($urandom_range(0, 7) != 0)
                        ? RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1))
                        : $urandom;
         im_we        = ($urandom_range(0, 2) == 0);
         im_waddr     = ($urandom_range(0, 5) != 0)
                        ? RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1))
                        : RESET_PC + 32'($urandom_range(0, 8 * IM_WORDS));
         im_wdata     = $urandom;
         tick();
      end
      im_we = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
